// File: rtl/alu_cmp_pipe_if.sv
// Handshake bundle for alu_cmp_pipe: operand beat in, result beat out,
// plus the true-result counter sideband. The master drives operands, the slave is the pipe.
`timescale 1ns/1ps

interface alu_cmp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUFun;
  logic             Sign;
  logic             out_valid;
  logic [WIDTH-1:0] S;
  logic             out_ready;
  logic             clr_cnt;
  logic [CNT_W-1:0] true_cnt;
  logic             illegal;

  modport master (
    output in_valid, A, B, ALUFun, Sign, out_ready, clr_cnt,
    input  in_ready, out_valid, S, true_cnt, illegal
  );

  modport slave (
    input  in_valid, A, B, ALUFun, Sign, out_ready, clr_cnt,
    output in_ready, out_valid, S, true_cnt, illegal
  );
endinterface

// File: rtl/alu_cmp_pipe.sv
// Two-stage compare pipe: stage 1 captures subtraction flags, stage 2 decodes
// the compare code into a 1-bit result. Counts consumed true results.
`timescale 1ns/1ps

module alu_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            reset,
  alu_cmp_pipe_if.slave  bus
);

  logic [WIDTH:0]   diff;
  logic             diffZero;
  logic             diffNeg;
  logic             diffOvf;
  logic             diffBorrow;
  logic             aSign;
  logic             aZero;

  logic             s1Valid_q, s1Valid_d;
  logic             zFlag_q, zFlag_d;
  logic             nFlag_q, nFlag_d;
  logic             vFlag_q, vFlag_d;
  logic             borrow_q, borrow_d;
  logic             aSign_q, aSign_d;
  logic             aZero_q, aZero_d;
  logic [2:0]       fun_q, fun_d;
  logic             sign_q, sign_d;

  logic             s2Valid_q, s2Valid_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic             s1Advance;
  logic             accept;
  logic             consume;
  logic             lessThan;
  logic             evalFlag;

  // Zero-extended subtract gives the unsigned borrow in the top bit.
  assign diff       = {1'b0, bus.A} - {1'b0, bus.B};
  assign diffZero   = (diff[WIDTH-1:0] == '0);
  assign diffNeg    = diff[WIDTH-1];
  assign diffOvf    = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (diff[WIDTH-1] ^ bus.A[WIDTH-1]);
  assign diffBorrow = diff[WIDTH];
  assign aSign      = bus.A[WIDTH-1];
  assign aZero      = (bus.A == '0);

  assign s1Advance  = !s2Valid_q || bus.out_ready;
  assign bus.in_ready = !s1Valid_q || s1Advance;
  assign accept     = bus.in_valid && bus.in_ready;
  assign consume    = s2Valid_q && bus.out_ready;

  always_comb begin
    lessThan = sign_q ? (nFlag_q ^ vFlag_q) : borrow_q;
    evalFlag = 1'b0;
    case (fun_q)
      3'b001:  evalFlag = zFlag_q;
      3'b000:  evalFlag = !zFlag_q;
      3'b010:  evalFlag = lessThan;
      3'b011:  evalFlag = !lessThan;
      3'b110:  evalFlag = sign_q ? (aSign_q || aZero_q) : aZero_q;
      3'b101:  evalFlag = sign_q ? aSign_q : 1'b0;
      3'b111:  evalFlag = sign_q ? (!aSign_q && !aZero_q) : !aZero_q;
      default: evalFlag = 1'b0;
    endcase
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    zFlag_d   = zFlag_q;
    nFlag_d   = nFlag_q;
    vFlag_d   = vFlag_q;
    borrow_d  = borrow_q;
    aSign_d   = aSign_q;
    aZero_d   = aZero_q;
    fun_d     = fun_q;
    sign_d    = sign_q;
    s2Valid_d = s2Valid_q;
    flag_d    = flag_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;

    if (accept) begin
      s1Valid_d = 1'b1;
      zFlag_d   = diffZero;
      nFlag_d   = diffNeg;
      vFlag_d   = diffOvf;
      borrow_d  = diffBorrow;
      aSign_d   = aSign;
      aZero_d   = aZero;
      fun_d     = bus.ALUFun;
      sign_d    = bus.Sign;
      illegal_d = (bus.ALUFun == 3'b100);
    end else if (s1Advance) begin
      s1Valid_d = 1'b0;
    end

    // Stage 2 only moves when its slot is free or being drained; S holds otherwise.
    if (s1Advance) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        flag_d = evalFlag;
      end
    end

    // A clear overrides an increment landing on the same edge.
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (consume && flag_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      zFlag_q   <= 1'b0;
      nFlag_q   <= 1'b0;
      vFlag_q   <= 1'b0;
      borrow_q  <= 1'b0;
      aSign_q   <= 1'b0;
      aZero_q   <= 1'b0;
      fun_q     <= 3'b000;
      sign_q    <= 1'b0;
      s2Valid_q <= 1'b0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      zFlag_q   <= zFlag_d;
      nFlag_q   <= nFlag_d;
      vFlag_q   <= vFlag_d;
      borrow_q  <= borrow_d;
      aSign_q   <= aSign_d;
      aZero_q   <= aZero_d;
      fun_q     <= fun_d;
      sign_q    <= sign_d;
      s2Valid_q <= s2Valid_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid = s2Valid_q;
  assign bus.S         = {{(WIDTH-1){1'b0}}, flag_q};
  assign bus.true_cnt  = cnt_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Scoreboard bench for alu_cmp_pipe: a behavioural compare model queues expected
// flags on acceptance; a negedge monitor pops them as results are consumed.
`timescale 1ns/1ps

module tb_alu_cmp_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  alu_cmp_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_cmp_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   assertCount = 0;
  int   failCount   = 0;
  logic sbQueue[$];
  int   modelCnt     = 0;
  logic modelIllegal = 1'b0;
  logic prevStall    = 1'b0;
  logic [WIDTH-1:0] prevS = '0;
  logic stimDone = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference compare written directly from the code table, using native SV compares.
  function automatic logic modelFlag(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] f, input logic s);
    logic lt;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    case (f)
      3'b001:  return a == b;
      3'b000:  return a != b;
      3'b010:  return lt;
      3'b011:  return !lt;
      3'b110:  return s ? ($signed(a) <= 0) : (a == 0);
      3'b101:  return s ? ($signed(a) < 0) : 1'b0;
      3'b111:  return s ? ($signed(a) > 0) : (a != 0);
      default: return 1'b0;
    endcase
  endfunction

  // Monitor sees settled values mid-cycle; whatever handshakes it sees fire on the next posedge.
  always @(negedge clk) begin
    logic expFlag;
    if (reset) begin
      sbQueue.delete();
      modelCnt     = 0;
      modelIllegal = 1'b0;
      prevStall    = 1'b0;
      checkOutput("rstOutValid", bus.out_valid, 0);
      checkOutput("rstS", bus.S, 0);
      checkOutput("rstTrueCnt", bus.true_cnt, 0);
      checkOutput("rstIllegal", bus.illegal, 0);
      checkOutput("rstInReady", bus.in_ready, 1);
    end else begin
      checkOutput("trueCnt", bus.true_cnt, modelCnt);
      checkOutput("illegal", bus.illegal, modelIllegal);
      if (prevStall) begin
        checkOutput("stallValid", bus.out_valid, 1);
        checkOutput("stallS", bus.S, prevS);
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("sbNotEmpty", sbQueue.size() > 0, 1);
        if (sbQueue.size() > 0) begin
          expFlag = sbQueue.pop_front();
          checkOutput("resultS", bus.S, {{(WIDTH-1){1'b0}}, expFlag});
          if (expFlag && modelCnt < CNT_MAX) modelCnt++;
        end
      end
      if (bus.clr_cnt) modelCnt = 0;
      if (bus.in_valid && bus.in_ready) begin
        sbQueue.push_back(modelFlag(bus.A, bus.B, bus.ALUFun, bus.Sign));
        modelIllegal = (bus.ALUFun == 3'b100);
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevS     = bus.S;
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] f, input logic s, output int cycles);
    logic rdy;
    bus.A        = a;
    bus.B        = b;
    bus.ALUFun   = f;
    bus.Sign     = s;
    bus.in_valid = 1'b1;
    cycles = 0;
    rdy = 1'b0;
    for (int t = 0; t < 50 && !rdy; t++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!rdy) checkOutput("acceptTimeout", rdy, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    logic done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      #1;
      done = (sbQueue.size() == 0) && !bus.out_valid;
    end
    if (!done) checkOutput("drainTimeout", done, 1);
  endtask

  task automatic waitOutValid();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk);
      #1;
      seen = bus.out_valid;
    end
    if (!seen) checkOutput("outValidTimeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int expSeq[5] = '{1, 2, 3, 3, 3};
    logic [WIDTH-1:0] ra, rb;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALUFun    = 3'b000;
    bus.Sign      = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_cnt   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("postRstInReady", bus.in_ready, 1);
    checkOutput("postRstOutValid", bus.out_valid, 0);
    checkOutput("postRstTrueCnt", bus.true_cnt, 0);

    $display("[TB] signed overflow compare and latency");
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b010, 1'b1, cyc);
    checkOutput("latencyStage1", bus.out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("latencyOutValid", bus.out_valid, 1);
    checkOutput("ovfLtS", bus.S, 0);
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b011, 1'b1, cyc);
    waitDrain();

    $display("[TB] unsigned versus signed less-than");
    applyStimulus(32'h1, 32'hFFFF_FFFF, 3'b010, 1'b0, cyc);
    applyStimulus(32'h1, 32'hFFFF_FFFF, 3'b010, 1'b1, cyc);
    waitDrain();

    $display("[TB] reserved code");
    applyStimulus(32'h1234, 32'h1234, 3'b100, 1'b0, cyc);
    waitDrain();
    checkOutput("illegalSet", bus.illegal, 1);
    applyStimulus(32'd5, 32'd5, 3'b001, 1'b0, cyc);
    waitDrain();
    checkOutput("illegalClr", bus.illegal, 0);
    checkOutput("eqS", bus.S, 1);

    $display("[TB] back-to-back stream with output stall");
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus(32'd9, 32'd9, 3'b001, 1'b0, cyc);
        applyStimulus(32'd9, 32'd9, 3'b000, 1'b0, cyc);
        applyStimulus(32'd3, 32'd7, 3'b010, 1'b0, cyc);
        applyStimulus(32'd0, 32'd7, 3'b110, 1'b1, cyc);
      end
      begin
        waitOutValid();
        checkOutput("fullInReady", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] saturating counter and clear");
    bus.clr_cnt = 1'b1;
    @(posedge clk);
    #1 bus.clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(32'd5, 32'd5, 3'b001, 1'b0, cyc);
      waitDrain();
      checkOutput("cntSeq", bus.true_cnt, expSeq[k]);
    end
    bus.out_ready = 1'b0;
    applyStimulus(32'd5, 32'd5, 3'b001, 1'b0, cyc);
    waitOutValid();
    bus.clr_cnt   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.clr_cnt = 1'b0;
    checkOutput("clrWins", bus.true_cnt, 0);
    waitDrain();

    $display("[TB] random stream with random back-pressure");
    stimDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          ra = $urandom;
          case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = '0;
            2: rb = 32'h8000_0000;
            default: rb = $urandom;
          endcase
          if ($urandom_range(0, 5) == 0) ra = '0;
          applyStimulus(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), cyc);
        end
        stimDone = 1'b1;
      end
      begin
        while (!stimDone) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    waitDrain();

    $display("[TB] asynchronous reset mid-stream");
    bus.out_ready = 1'b0;
    applyStimulus(32'd1, 32'd1, 3'b001, 1'b0, cyc);
    applyStimulus(32'd2, 32'd2, 3'b001, 1'b0, cyc);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstOutValid", bus.out_valid, 0);
    checkOutput("asyncRstS", bus.S, 0);
    checkOutput("asyncRstTrueCnt", bus.true_cnt, 0);
    checkOutput("asyncRstInReady", bus.in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("relOutValid", bus.out_valid, 0);
    applyStimulus(32'hFFFF_FFFF, 32'd0, 3'b101, 1'b1, cyc);
    checkOutput("firstBeatCycles", cyc, 1);
    waitDrain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
